dac_stream_ctl: RTL and testbench
=================================

# dac_stream_ctl

Sequencer that feeds the Spartan-3 DDR DAC output cells from a two's-complement sample stream, or from a static test word, and keeps the converter at midscale whenever no valid data is live. It accepts one sample pair per clock over a valid/ready handshake and converts it to offset binary. It rides out short stream gaps by holding the last pair, counts underflow events, and drives the `data0`/`data1` inputs of the DAC output cell bank directly.

## Interface
- `width`, 16: sample width, equal to the DAC cell width.
- `hold_max`, 4: consecutive empty cycles tolerated in RUN before falling back to midscale; legal range 1..255.
- `clk`  in  1: DAC clock, shared with the DDR output cells.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: level; high runs the sequencer, low forces IDLE.
- `src_sel`  in  1: 0 = stream, 1 = test pattern; latched on leaving IDLE.
- `pat_word`  in  width: test word, two's complement; used on both phases.
- `s_valid`  in  1: stream pair valid.
- `s_ready`  out  1: stream pair accepted when `s_valid & s_ready`.
- `s_data0`  in  width: stream sample for the rising phase, two's complement.
- `s_data1`  in  width: stream sample for the falling phase, two's complement.
- `data0`  out  width: offset-binary rising-phase sample to the DAC cells.
- `data1`  out  width: offset-binary falling-phase sample to the DAC cells.
- `running`  out  1: high while the outputs carry live stream or pattern data.
- `underflow`  out  1: one-cycle pulse per underflow event.
- `underflow_count`  out  16: saturating count of underflow events.

## Operation
- Conversion: `off = {~d[width-1], d[width-2:0]}`. Midscale MID = 1<<(width-1). No rounding and no width change.
- States:
  - **IDLE:** `s_ready`=0; outputs MID; `running`=0. Goes to PRIME when `enable`=1 and `src_sel`=0, or to PAT when `enable`=1 and `src_sel`=1.
  - **PRIME:** `s_ready`=1; outputs MID. On the first accepted pair, registers that pair and goes to RUN.
  - **RUN:** `s_ready`=1; `running`=1.
    - Accepted pair: registered and output.
    - `s_valid`=0: go to GAP, gap counter = 1, outputs hold the last pair.
  - **GAP:** `s_ready`=1; outputs hold.
    - Accepted pair: output it and return to RUN.
    - Otherwise the gap counter increments.
    - Gap counter reaching `hold_max` without data: pulse `underflow`, increment `underflow_count` (saturating at 0xFFFF), output MID, go to PRIME.
  - **PAT:** `s_ready`=0; `data0`=`data1`=`off(pat_word)`, tracking `pat_word` with 1-cycle latency; `running`=1.
- `enable`=0 in any state: next state IDLE; outputs MID on the next edge. Any pair offered in that cycle is not accepted (`s_ready` is 0 combinationally when `enable`=0).
- `src_sel` changes outside IDLE are ignored until the next pass through IDLE.
- `underflow_count` is cleared only by `rst`.

## Timing
- Reset values: state IDLE, `data0`=`data1`=MID, `s_ready`=0, `running`=0, `underflow`=0, `underflow_count`=0, gap counter 0.
- Latency: a pair accepted at edge N appears on `data0`/`data1` after edge N.
- `data0` and `data1` update on the same rising edge; the DAC cell retimes `data1` to the opposite phase.
- `s_ready` is a function of state and `enable` only, never of `s_valid`.
- Underflow timing: the last pair is held for exactly `hold_max` cycles after the final accepted pair; MID appears on the following edge, coincident with the `underflow` pulse.
- `rst` mid-stream wins over `enable` and any handshake; all outputs take reset values on the next edge.

## Structure
- Shared package `dac_pkg`:
  - state encoding (IDLE, PRIME, RUN, GAP, PAT);
  - function `to_offset(d)`;
  - function `midscale(width)`.
- Single flat module with no sub-module. The gap counter is 8 bits; `underflow_count` is a 16-bit saturating register.

## Test plan
- Reset then `enable`=1 with `s_valid`=0 for 10 cycles -> state PRIME, `data0`=`data1`=16'h8000, `running`=0.
- Stream 0x0000/0x7FFF, then 0x8000/0xFFFF, back-to-back -> outputs 0x8000/0xFFFF, then 0x0000/0x7FFF, one cycle after each accept; `s_ready` stays 1.
- Gap of 3 cycles with `hold_max`=4 -> last pair held 3 cycles, no `underflow` pulse, stream resumes. Gap of 4 cycles -> one `underflow` pulse, MID output, `underflow_count`=1, back in PRIME.
- Force 0xFFFF underflows (or preload the counter) -> `underflow_count` stays 0xFFFF.
- `src_sel`=1, `pat_word`=16'h1234 -> both outputs 0x9234, `s_ready`=0. Toggle `src_sel` while in PAT -> no effect until `enable` is cycled.
- Drop `enable` mid-RUN with `s_valid`=1 -> that pair is not accepted, MID on the next edge, IDLE. Assert `rst` mid-GAP -> all reset values, and `underflow_count` returns to 0.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC stream sequencer.
//   dac_state_e : sequencer state encoding
//   midscale()  : offset-binary midscale code for a given sample width
//   to_offset() : two's complement to offset binary (flip the sign bit)
// Helpers work on a MaxWidth-bit container; callers cast the result to their width.
package dac_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StRun,
        StGap,
        StPat
    } dac_state_e;

    function automatic logic [MaxWidth-1:0] midscale(input int unsigned width);
        return MaxWidth'(1) << (width - 1);
    endfunction

    function automatic logic [MaxWidth-1:0] to_offset(input logic [MaxWidth-1:0] d,
                                                     input int unsigned width);
        return d ^ midscale(width);
    endfunction

endpackage

// File: rtl/dac_stream_ctl.sv
// Sequencer feeding the DDR DAC output cell bank.
// Converts a two's-complement sample-pair stream (or a static test word) to offset binary,
// holds the last pair across short stream gaps and parks the DAC at midscale otherwise.
// Ports:
//   clk, rst          : DAC clock, synchronous active-high reset
//   enable            : level; low forces IDLE (midscale)
//   src_sel           : 0 stream, 1 test pattern; sampled when leaving IDLE
//   pat_word          : test word (two's complement), driven on both phases
//   s_valid/s_ready   : stream handshake; s_data0/s_data1 rising/falling-phase samples
//   data0/data1       : offset-binary samples to the DAC cells (same edge)
//   running           : outputs carry live stream or pattern data
//   underflow         : one-cycle pulse per underflow event
//   underflow_count   : saturating underflow event count, cleared only by rst
module dac_stream_ctl
    import dac_pkg::*;
#(
    parameter int unsigned width    = 16,
    parameter int unsigned hold_max = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             src_sel,
    input  logic [width-1:0] pat_word,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [width-1:0] s_data0,
    input  logic [width-1:0] s_data1,
    output logic [width-1:0] data0,
    output logic [width-1:0] data1,
    output logic             running,
    output logic             underflow,
    output logic [15:0]      underflow_count
);

    localparam logic [8:0] HoldMax9 = 9'(hold_max);

    dac_state_e       state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic [width-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             uf_q, uf_d;
    logic [15:0]      uf_cnt_q, uf_cnt_d;

    logic [width-1:0] mid, s0_off, s1_off, pat_off;
    logic             accept;
    logic             starve;

    assign mid     = width'(midscale(width));
    assign s0_off  = width'(to_offset(MaxWidth'(s_data0), width));
    assign s1_off  = width'(to_offset(MaxWidth'(s_data1), width));
    assign pat_off = width'(to_offset(MaxWidth'(pat_word), width));

    // Ready depends on state and enable only, never on s_valid.
    assign s_ready = enable & (state_q inside {StPrime, StRun, StGap});
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        uf_d     = 1'b0;
        uf_cnt_d = uf_cnt_q;
        starve   = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            gap_d   = '0;
            data0_d = mid;
            data1_d = mid;
        end else begin
            unique case (state_q)
                StIdle: begin
                    gap_d = '0;
                    if (src_sel) begin
                        // Load the pattern on the leaving edge so PAT never shows stale MID.
                        state_d = StPat;
                        data0_d = pat_off;
                        data1_d = pat_off;
                    end else begin
                        state_d = StPrime;
                        data0_d = mid;
                        data1_d = mid;
                    end
                end
                StPrime: begin
                    if (accept) begin
                        state_d = StRun;
                        data0_d = s0_off;
                        data1_d = s1_off;
                    end
                end
                StRun: begin
                    if (accept) begin
                        data0_d = s0_off;
                        data1_d = s1_off;
                        gap_d   = '0;
                    end else if (HoldMax9 <= 9'd1) begin
                        starve = 1'b1;
                    end else begin
                        state_d = StGap;
                        gap_d   = 8'd1;
                    end
                end
                StGap: begin
                    if (accept) begin
                        state_d = StRun;
                        data0_d = s0_off;
                        data1_d = s1_off;
                        gap_d   = '0;
                    end else if (({1'b0, gap_q} + 9'd1) >= HoldMax9) begin
                        starve = 1'b1;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                StPat: begin
                    data0_d = pat_off;
                    data1_d = pat_off;
                end
                default: begin
                    state_d = StIdle;
                    data0_d = mid;
                    data1_d = mid;
                end
            endcase
        end

        // Stream ran dry: park at midscale and wait for the next pair in PRIME.
        if (starve) begin
            state_d = StPrime;
            gap_d   = '0;
            data0_d = mid;
            data1_d = mid;
            uf_d    = 1'b1;
            if (uf_cnt_q != 16'hFFFF) begin
                uf_cnt_d = uf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            data0_q  <= mid;
            data1_q  <= mid;
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            uf_q     <= uf_d;
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign data0           = data0_q;
    assign data1           = data1_q;
    assign running         = state_q inside {StRun, StGap, StPat};
    assign underflow       = uf_q;
    assign underflow_count = uf_cnt_q;

endmodule

// File: tb/tb_dac_stream_ctl.sv
// Self-checking bench for dac_stream_ctl (width 16, hold_max 4).
// Stream pairs push their expected offset-binary outputs onto a scoreboard queue when driven;
// entries are popped and compared once the DUT has registered the pair.
module tb_dac_stream_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        src_sel;
    logic [15:0] pat_word;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data0;
    logic [15:0] s_data1;
    logic [15:0] data0;
    logic [15:0] data1;
    logic        running;
    logic        underflow;
    logic [15:0] underflow_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb_q[$];
    logic [15:0] last0, last1;

    dac_stream_ctl #(
        .width    (16),
        .hold_max (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .src_sel         (src_sel),
        .pat_word        (pat_word),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data0         (s_data0),
        .s_data1         (s_data1),
        .data0           (data0),
        .data1           (data1),
        .running         (running),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] off(input logic [15:0] d);
        return {~d[15], d[14:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pair, record its expectation, clock it in and compare.
    task automatic send_pair(input logic [15:0] d0, input logic [15:0] d1, input string name);
        logic [31:0] exp;
        s_valid = 1'b1;
        s_data0 = d0;
        s_data1 = d1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s s_ready: got %b want 1", name, s_ready);
        end
        sb_q.push_back({off(d0), off(d1)});
        tick();
        s_valid = 1'b0;
        exp = sb_q.pop_front();
        total++;
        if ({data0, data1} !== exp) begin
            bad++;
            $display("FAIL %s data: got %h/%h want %h/%h", name, data0, data1, exp[31:16],
                     exp[15:0]);
        end
        last0 = exp[31:16];
        last1 = exp[15:0];
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; src_sel = 1'b0; pat_word = '0;
        s_valid = 1'b0; s_data0 = '0; s_data1 = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if (data0 !== 16'h8000 || data1 !== 16'h8000) begin
            bad++; $display("FAIL reset data: got %h/%h want 8000/8000", data0, data1);
        end
        total++;
        if ({s_ready, running, underflow} !== 3'b000) begin
            bad++;
            $display("FAIL reset flags: got rdy=%b run=%b uf=%b want 000", s_ready, running,
                     underflow);
        end
        total++;
        if (underflow_count !== 16'h0000) begin
            bad++; $display("FAIL reset count: got %h want 0000", underflow_count);
        end
    endtask

    task automatic test_prime();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (data0 !== 16'h8000 || data1 !== 16'h8000 || running !== 1'b0 || s_ready !== 1'b1)
        begin
            bad++;
            $display("FAIL prime: got %h/%h run=%b rdy=%b want 8000/8000 run=0 rdy=1", data0,
                     data1, running, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        send_pair(16'h0000, 16'h7FFF, "b2b_first");
        send_pair(16'h8000, 16'hFFFF, "b2b_second");
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL b2b running: got %b want 1", running);
        end
        for (int i = 0; i < 6; i++) begin
            send_pair(16'($urandom), 16'($urandom), "b2b_random");
        end
    endtask

    task automatic test_gap();
        // Gap of 3: held, no underflow, stream resumes.
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (data0 !== last0 || data1 !== last1 || underflow !== 1'b0 || running !== 1'b1)
            begin
                bad++;
                $display("FAIL gap3 hold %0d: got %h/%h uf=%b run=%b want %h/%h uf=0 run=1", i,
                         data0, data1, underflow, running, last0, last1);
            end
        end
        send_pair(16'h1111, 16'hEEEE, "gap3_resume");
        // Gap of 4: underflow.
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (data0 !== last0 || data1 !== last1 || underflow !== 1'b0) begin
                bad++;
                $display("FAIL gap4 hold %0d: got %h/%h uf=%b want %h/%h uf=0", i, data0, data1,
                         underflow, last0, last1);
            end
        end
        tick();
        total++;
        if (underflow !== 1'b1 || data0 !== 16'h8000 || data1 !== 16'h8000) begin
            bad++;
            $display("FAIL gap4 underflow: got uf=%b %h/%h want uf=1 8000/8000", underflow,
                     data0, data1);
        end
        total++;
        if (underflow_count !== 16'd1 || running !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL gap4 state: got cnt=%h run=%b rdy=%b want cnt=0001 run=0 rdy=1",
                     underflow_count, running, s_ready);
        end
        tick();
        total++;
        if (underflow !== 1'b0) begin
            bad++; $display("FAIL gap4 pulse width: got uf=%b want 0", underflow);
        end
    endtask

    task automatic test_saturate();
        force dut.uf_cnt_q = 16'hFFFE;
        tick();
        release dut.uf_cnt_q;
        tick();
        for (int n = 0; n < 2; n++) begin
            send_pair(16'h2222, 16'h3333, "sat_prime");
            for (int i = 0; i < 4; i++) tick();
            total++;
            if (underflow !== 1'b1 || underflow_count !== 16'hFFFF) begin
                bad++;
                $display("FAIL saturate %0d: got uf=%b cnt=%h want uf=1 cnt=ffff", n, underflow,
                         underflow_count);
            end
        end
    endtask

    task automatic test_pattern();
        enable = 1'b0;
        tick();
        src_sel = 1'b1; pat_word = 16'h1234; enable = 1'b1;
        tick();
        total++;
        if (data0 !== 16'h9234 || data1 !== 16'h9234 || s_ready !== 1'b0 || running !== 1'b1)
        begin
            bad++;
            $display("FAIL pat 1234: got %h/%h rdy=%b run=%b want 9234/9234 rdy=0 run=1",
                     data0, data1, s_ready, running);
        end
        pat_word = 16'hFEDC;
        #1;
        total++;
        if (data0 !== 16'h9234) begin
            bad++; $display("FAIL pat latency: got %h want 9234", data0);
        end
        tick();
        total++;
        if (data0 !== off(16'hFEDC) || data1 !== off(16'hFEDC)) begin
            bad++;
            $display("FAIL pat track: got %h/%h want %h", data0, data1, off(16'hFEDC));
        end
        src_sel = 1'b0;
        s_valid = 1'b1;
        tick(); tick();
        s_valid = 1'b0;
        total++;
        if (data0 !== 16'h7EDC || s_ready !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL pat src_sel ignored: got %h rdy=%b run=%b want 7edc rdy=0 run=1",
                     data0, s_ready, running);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        total++;
        if (data0 !== 16'h8000 || s_ready !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL pat re-enable: got %h rdy=%b run=%b want 8000 rdy=1 run=0", data0,
                     s_ready, running);
        end
    endtask

    task automatic test_enable_drop();
        send_pair(16'h4000, 16'hC000, "drop_prime");
        s_valid = 1'b1; s_data0 = 16'h5555; s_data1 = 16'hAAAA; enable = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++; $display("FAIL drop s_ready: got %b want 0", s_ready);
        end
        tick();
        total++;
        if (data0 !== 16'h8000 || data1 !== 16'h8000 || running !== 1'b0) begin
            bad++;
            $display("FAIL drop mid: got %h/%h run=%b want 8000/8000 run=0", data0, data1,
                     running);
        end
        s_valid = 1'b0; enable = 1'b1;
        tick();
        total++;
        if (data0 !== 16'h8000 || s_ready !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL drop not accepted: got %h rdy=%b run=%b want 8000 rdy=1 run=0",
                     data0, s_ready, running);
        end
    endtask

    task automatic test_rst_mid_gap();
        send_pair(16'h0123, 16'h4567, "rst_prime");
        tick(); tick();
        total++;
        if (data0 !== last0 || running !== 1'b1) begin
            bad++;
            $display("FAIL rst pre-gap: got %h run=%b want %h run=1", data0, running, last0);
        end
        rst = 1'b1; s_valid = 1'b1;
        tick();
        total++;
        if (data0 !== 16'h8000 || data1 !== 16'h8000 || s_ready !== 1'b0 || running !== 1'b0 ||
            underflow !== 1'b0 || underflow_count !== 16'h0000) begin
            bad++;
            $display("FAIL rst mid-gap: got %h/%h rdy=%b run=%b uf=%b cnt=%h want reset values",
                     data0, data1, s_ready, running, underflow, underflow_count);
        end
        rst = 1'b0; s_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_prime();
        test_back_to_back();
        test_gap();
        test_saturate();
        test_pattern();
        test_enable_drop();
        test_rst_mid_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
